// File: rtl/edge_event_scheduler.sv
// edge_event_scheduler: synchronises and edge-detects CHANNELS raw inputs,
// holds one pending event per channel, and serialises pending events onto a
// single valid/ready port through a round-robin arbiter. Edges that arrive
// while a channel's previous event is still waiting are dropped and flagged
// in a sticky per-channel overflow vector.
module edge_event_scheduler #(
  parameter int CHANNELS    = 4,
  parameter bit ACTIVE_LOW  = 1'b0,
  parameter bit DETECT_RISE = 1'b1,
  parameter bit DETECT_FALL = 1'b1,
  parameter int CHW         = $clog2(CHANNELS)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] IN,
  input  logic [CHANNELS-1:0] EN,
  output logic                EVT_VALID,
  input  logic                EVT_READY,
  output logic [CHW-1:0]      EVT_CHANNEL,
  output logic                EVT_RISING,
  output logic [CHANNELS-1:0] OVERFLOW,
  input  logic                OVF_CLEAR
);

  // Active-level view of the inputs; everything downstream works in this polarity.
  logic [CHANNELS-1:0] active;
  assign active = IN ^ {CHANNELS{ACTIVE_LOW}};

  // Sampling stages, pending bank, sticky overflow, arbiter pointer, output register
  logic [CHANNELS-1:0] s0_reg, s1_reg;
  logic [CHANNELS-1:0] pend_reg, pend_next;
  logic [CHANNELS-1:0] kind_reg, kind_next;
  logic [CHANNELS-1:0] ovf_reg, ovf_next, ovf_set;
  logic [CHW-1:0]      ptr_reg, ptr_next;
  logic                valid_reg;
  logic [CHW-1:0]      chan_reg;
  logic                rising_reg;

  // Arbiter results
  logic [CHANNELS-1:0] req;
  logic [CHANNELS-1:0] granted;
  logic                any_req;
  logic [CHW-1:0]      win_idx;
  logic                load_en;
  logic                do_grant;

  // Per-channel edge qualification
  logic [CHANNELS-1:0] edge_seen;
  logic [CHANNELS-1:0] counted;
  logic [CHANNELS-1:0] blocked;

  // The output register may take a new event when empty or when the current one is leaving.
  assign load_en  = ~valid_reg | EVT_READY;
  assign do_grant = load_en & any_req;

  // Disabled channels never compete, even in the cycle their pending bit is being cleared.
  assign req = pend_reg & EN;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign edge_seen[gi] = s0_reg[gi] ^ s1_reg[gi];
      // s0 holds the new level, so s0 = 1 means an active-going edge.
      assign counted[gi]   = edge_seen[gi] & EN[gi] &
                             (s0_reg[gi] ? DETECT_RISE : DETECT_FALL);
      assign granted[gi]   = do_grant & (win_idx == CHW'(gi));
      // A still-waiting event (not leaving this cycle) blocks a new one.
      assign blocked[gi]   = pend_reg[gi] & ~granted[gi];
      assign ovf_set[gi]   = counted[gi] & blocked[gi];
      assign pend_next[gi] = EN[gi] & (counted[gi] | blocked[gi]);
      assign kind_next[gi] = (counted[gi] & ~blocked[gi]) ? s0_reg[gi] : kind_reg[gi];
    end
  endgenerate

  // Set beats clear when both hit the same bit in one cycle.
  assign ovf_next = (ovf_reg & ~{CHANNELS{OVF_CLEAR}}) | ovf_set;

  // Round-robin search: first requesting channel at or after ptr_reg, wrapping to 0.
  always_comb begin
    logic [CHW:0] cand_sum;
    logic [CHW-1:0] cand;
    any_req  = 1'b0;
    win_idx  = '0;
    cand_sum = '0;
    cand     = '0;
    for (int off = 0; off < CHANNELS; off++) begin
      cand_sum = {1'b0, ptr_reg} + (CHW+1)'(off);
      if (cand_sum >= (CHW+1)'(CHANNELS)) begin
        cand_sum = cand_sum - (CHW+1)'(CHANNELS);
      end
      cand = cand_sum[CHW-1:0];
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
  end

  // Pointer moves to the slot after the winner so the winner goes to the back of the queue.
  always_comb begin
    ptr_next = ptr_reg;
    if (do_grant) begin
      ptr_next = (win_idx == CHW'(CHANNELS-1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Synchroniser stages; in reset both load the current level so a held level gives no edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_reg <= active;
      s1_reg <= active;
    end else begin
      s0_reg <= active;
      s1_reg <= s0_reg;
    end
  end

  // Pending bank, kind bits, sticky overflow and arbiter pointer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_reg <= '0;
      kind_reg <= '0;
      ovf_reg  <= '0;
      ptr_reg  <= '0;
    end else begin
      pend_reg <= pend_next;
      kind_reg <= kind_next;
      ovf_reg  <= ovf_next;
      ptr_reg  <= ptr_next;
    end
  end

  // Output register: reloads whenever loadable, otherwise holds the presented event.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_reg  <= 1'b0;
      chan_reg   <= '0;
      rising_reg <= 1'b0;
    end else if (load_en) begin
      valid_reg <= any_req;
      if (any_req) begin
        chan_reg   <= win_idx;
        rising_reg <= kind_reg[win_idx];
      end
    end
  end

  assign EVT_VALID   = valid_reg;
  assign EVT_CHANNEL = chan_reg;
  assign EVT_RISING  = rising_reg;
  assign OVERFLOW    = ovf_reg;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed testbench for edge_event_scheduler: a vector table for the
// steady-state sequences plus hand-written multi-cycle corner cases.
module tb_edge_event_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_v;
  logic [3:0] en;
  logic       ready;
  logic       ovf_clear;

  logic       evt_valid;
  logic [1:0] evt_channel;
  logic       evt_rising;
  logic [3:0] overflow;

  logic       nf_valid;
  logic [1:0] nf_channel;
  logic       nf_rising;
  logic [3:0] nf_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edge_event_scheduler #(
    .CHANNELS(4), .ACTIVE_LOW(1'b0), .DETECT_RISE(1'b1), .DETECT_FALL(1'b1)
  ) dut (
    .CLK(clk), .RST(rst), .IN(in_v), .EN(en),
    .EVT_VALID(evt_valid), .EVT_READY(ready), .EVT_CHANNEL(evt_channel),
    .EVT_RISING(evt_rising), .OVERFLOW(overflow), .OVF_CLEAR(ovf_clear)
  );

  // Second instance with falling-edge detection disabled.
  edge_event_scheduler #(
    .CHANNELS(4), .ACTIVE_LOW(1'b0), .DETECT_RISE(1'b1), .DETECT_FALL(1'b0)
  ) dut_nf (
    .CLK(clk), .RST(rst), .IN(in_v), .EN(en),
    .EVT_VALID(nf_valid), .EVT_READY(ready), .EVT_CHANNEL(nf_channel),
    .EVT_RISING(nf_rising), .OVERFLOW(nf_overflow), .OVF_CLEAR(ovf_clear)
  );

  typedef struct packed {
    logic [3:0] in;
    logic [3:0] en;
    logic       v;
    logic [1:0] ch;
    logic       r;
  } vec_t;

  vec_t tbl [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compare the main instance's outputs; channel/kind only matter while valid.
  task automatic check_out(input string name, input logic v, input logic [1:0] ch,
                           input logic r, input logic [3:0] ovf);
    $display("%0t %s: in=%b en=%b rdy=%b valid=%0b ch=%0d rising=%0b ovf=%b",
             $time, name, in_v, en, ready, evt_valid, evt_channel, evt_rising, overflow);
    chk({name, ".valid"}, {31'd0, evt_valid}, {31'd0, v});
    if (v) begin
      chk({name, ".channel"}, {30'd0, evt_channel}, {30'd0, ch});
      chk({name, ".rising"}, {31'd0, evt_rising}, {31'd0, r});
    end
    chk({name, ".overflow"}, {28'd0, overflow}, {28'd0, ovf});
  endtask

  task automatic check_nf(input string name, input logic v, input logic [1:0] ch);
    $display("%0t %s: in=%b valid=%0b ch=%0d rising=%0b", $time, name, in_v,
             nf_valid, nf_channel, nf_rising);
    chk({name, ".valid"}, {31'd0, nf_valid}, {31'd0, v});
    if (v) begin
      chk({name, ".channel"}, {30'd0, nf_channel}, {30'd0, ch});
      chk({name, ".rising"}, {31'd0, nf_rising}, 32'd1);
    end
  endtask

  // Drive inputs, let one rising edge consume them, return at the following falling edge.
  task automatic cyc(input logic [3:0] i, input logic rd);
    in_v  = i;
    ready = rd;
    @(negedge clk);
  endtask

  initial begin
    // Round-robin 0,1,3 then falls 0,3, single edge on 2, then masking of channel 3.
    tbl[0]  = '{4'b0000, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{4'b1011, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{4'b1011, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{4'b1011, 4'hF, 1'b1, 2'd0, 1'b1};
    tbl[4]  = '{4'b1011, 4'hF, 1'b1, 2'd1, 1'b1};
    tbl[5]  = '{4'b1011, 4'hF, 1'b1, 2'd3, 1'b1};
    tbl[6]  = '{4'b1011, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[7]  = '{4'b0010, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[8]  = '{4'b0010, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[9]  = '{4'b0010, 4'hF, 1'b1, 2'd0, 1'b0};
    tbl[10] = '{4'b0010, 4'hF, 1'b1, 2'd3, 1'b0};
    tbl[11] = '{4'b0010, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[12] = '{4'b0110, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[13] = '{4'b0110, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[14] = '{4'b0110, 4'hF, 1'b1, 2'd2, 1'b1};
    tbl[15] = '{4'b0110, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[16] = '{4'b0110, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[17] = '{4'b1110, 4'h7, 1'b0, 2'd0, 1'b0};
    tbl[18] = '{4'b0110, 4'h7, 1'b0, 2'd0, 1'b0};
    tbl[19] = '{4'b1110, 4'h7, 1'b0, 2'd0, 1'b0};
    tbl[20] = '{4'b0110, 4'h7, 1'b0, 2'd0, 1'b0};
    tbl[21] = '{4'b0110, 4'h7, 1'b0, 2'd0, 1'b0};
    tbl[22] = '{4'b0110, 4'h7, 1'b0, 2'd0, 1'b0};
    tbl[23] = '{4'b0110, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[24] = '{4'b0110, 4'hF, 1'b0, 2'd0, 1'b0};
    tbl[25] = '{4'b0110, 4'hF, 1'b0, 2'd0, 1'b0};

    // Reset held three cycles with a static non-zero input pattern.
    rst = 1'b1; in_v = 4'b0101; en = 4'hF; ready = 1'b1; ovf_clear = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.valid", {31'd0, evt_valid}, 32'd0);
    chk("reset.channel", {30'd0, evt_channel}, 32'd0);
    chk("reset.rising", {31'd0, evt_rising}, 32'd0);
    chk("reset.overflow", {28'd0, overflow}, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0101, 1'b1);
      check_out($sformatf("idle%0d", i), 1'b0, 2'd0, 1'b0, 4'b0000);
    end

    // Re-reset with all inputs low: the level change is absorbed by reset.
    rst = 1'b1;
    cyc(4'b0000, 1'b1);
    rst = 1'b0;
    check_out("rereset", 1'b0, 2'd0, 1'b0, 4'b0000);

    for (int i = 0; i < 26; i++) begin
      en = tbl[i].en;
      cyc(tbl[i].in, 1'b1);
      check_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].ch, tbl[i].r, 4'b0000);
    end

    // Backpressure and overflow on channel 1.
    rst = 1'b1; en = 4'hF;
    cyc(4'b0000, 1'b1);
    rst = 1'b0;
    cyc(4'b0010, 1'b0); check_out("bp1", 1'b0, 2'd0, 1'b0, 4'b0000);
    cyc(4'b0010, 1'b0); check_out("bp2", 1'b0, 2'd0, 1'b0, 4'b0000);
    cyc(4'b0010, 1'b0); check_out("bp3", 1'b1, 2'd1, 1'b1, 4'b0000);
    cyc(4'b0010, 1'b0); check_out("bp4", 1'b1, 2'd1, 1'b1, 4'b0000);
    cyc(4'b0000, 1'b0); check_out("bp5", 1'b1, 2'd1, 1'b1, 4'b0000);
    cyc(4'b0000, 1'b0); check_out("bp6", 1'b1, 2'd1, 1'b1, 4'b0000);
    cyc(4'b0010, 1'b0); check_out("bp7", 1'b1, 2'd1, 1'b1, 4'b0000);
    cyc(4'b0010, 1'b0); check_out("bp8", 1'b1, 2'd1, 1'b1, 4'b0010);
    cyc(4'b0010, 1'b0); check_out("bp9", 1'b1, 2'd1, 1'b1, 4'b0010);
    cyc(4'b0010, 1'b1); check_out("bp10", 1'b1, 2'd1, 1'b0, 4'b0010);
    cyc(4'b0010, 1'b1); check_out("bp11", 1'b0, 2'd0, 1'b0, 4'b0010);
    cyc(4'b0010, 1'b1); check_out("bp12", 1'b0, 2'd0, 1'b0, 4'b0010);
    ovf_clear = 1'b1;
    cyc(4'b0010, 1'b1); check_out("bp13", 1'b0, 2'd0, 1'b0, 4'b0000);
    ovf_clear = 1'b0;
    cyc(4'b0010, 1'b1); check_out("bp14", 1'b0, 2'd0, 1'b0, 4'b0000);

    // Reset while an event is presented and another is pending discards both.
    cyc(4'b0001, 1'b0); check_out("mid1", 1'b0, 2'd0, 1'b0, 4'b0000);
    cyc(4'b0001, 1'b0); check_out("mid2", 1'b0, 2'd0, 1'b0, 4'b0000);
    cyc(4'b0001, 1'b0); check_out("mid3", 1'b1, 2'd0, 1'b1, 4'b0000);
    cyc(4'b0001, 1'b0); check_out("mid4", 1'b1, 2'd0, 1'b1, 4'b0000);
    rst = 1'b1;
    cyc(4'b0001, 1'b0);
    rst = 1'b0;
    chk("mid_reset.valid", {31'd0, evt_valid}, 32'd0);
    chk("mid_reset.channel", {30'd0, evt_channel}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0001, 1'b1);
      check_out($sformatf("midpost%0d", i), 1'b0, 2'd0, 1'b0, 4'b0000);
    end

    // Channel 2 grant coincides with detection of its next edge.
    cyc(4'b0101, 1'b1); check_out("sim1", 1'b0, 2'd0, 1'b0, 4'b0000);
    cyc(4'b0001, 1'b1); check_out("sim2", 1'b0, 2'd0, 1'b0, 4'b0000);
    cyc(4'b0001, 1'b1); check_out("sim3", 1'b1, 2'd2, 1'b1, 4'b0000);
    cyc(4'b0001, 1'b1); check_out("sim4", 1'b1, 2'd2, 1'b0, 4'b0000);
    cyc(4'b0001, 1'b1); check_out("sim5", 1'b0, 2'd0, 1'b0, 4'b0000);
    cyc(4'b0001, 1'b1); check_out("sim6", 1'b0, 2'd0, 1'b0, 4'b0000);

    // Falling edges produce nothing on the rise-only instance.
    rst = 1'b1;
    cyc(4'b0000, 1'b1);
    rst = 1'b0;
    cyc(4'b1111, 1'b1); check_nf("nf1", 1'b0, 2'd0);
    cyc(4'b1111, 1'b1); check_nf("nf2", 1'b0, 2'd0);
    cyc(4'b1111, 1'b1); check_nf("nf3", 1'b1, 2'd0);
    cyc(4'b1111, 1'b1); check_nf("nf4", 1'b1, 2'd1);
    cyc(4'b1111, 1'b1); check_nf("nf5", 1'b1, 2'd2);
    cyc(4'b1111, 1'b1); check_nf("nf6", 1'b1, 2'd3);
    cyc(4'b1111, 1'b1); check_nf("nf7", 1'b0, 2'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(4'b0000, 1'b1);
      check_nf($sformatf("nffall%0d", i), 1'b0, 2'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
